// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one SDRAM controller port between a download stream and round-robin byte clients
module ram_port_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_WIDTH  = 23,
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk_sys,
  input  logic                              reset,
  input  logic                              dl_active,
  input  logic                              dl_wr,
  input  logic [ADDR_WIDTH-1:0]             dl_addr,
  input  logic [DATA_WIDTH-1:0]             dl_data,
  output logic                              dl_overrun,
  input  logic [NUM_CLIENTS-1:0]            cl_req,
  input  logic [NUM_CLIENTS-1:0]            cl_we,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]            cl_ack,
  output logic                              cl_err,
  output logic [DATA_WIDTH-1:0]             cl_rdata,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_din,
  input  logic [DATA_WIDTH-1:0]             mem_dout,
  output logic                              mem_we,
  output logic                              mem_rd,
  input  logic                              mem_ready,
  output logic                              busy
);
  localparam int IW = NUM_CLIENTS > 1 ? $clog2(NUM_CLIENTS) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_next;
  logic                  hold_valid;
  logic [ADDR_WIDTH-1:0] hold_addr, lat_addr;
  logic [DATA_WIDTH-1:0] hold_data, lat_data;
  logic [IW-1:0]         ptr, idx, sel, cand;
  logic                  found, lat_we, gnt_dl, err, consume, timeout_hit;
  logic [15:0]           cnt;
  // first requester after the pointer wins, so the last-served client goes to the back
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    cand  = ptr;
    for (int i = 1; i <= NUM_CLIENTS; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_CLIENTS);
      if (!found && cl_req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end
  assign consume     = state == IDLE && hold_valid;
  assign timeout_hit = cnt == 16'(TIMEOUT - 1);
  always_comb begin
    state_next = state == IDLE ? ((hold_valid || (!dl_active && found)) ? BUSY : IDLE)
               : state == BUSY ? ((mem_ready || timeout_hit) ? DONE : BUSY)
               : IDLE;
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_next;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      dl_overrun <= 1'b0;
      ptr        <= IW'(NUM_CLIENTS - 1);
      idx        <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_we     <= 1'b0;
      gnt_dl     <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
      cl_rdata   <= '0;
    end else begin
      // a byte arriving on the consume edge refills the hold instead of overrunning it
      if (dl_wr && (!hold_valid || consume)) begin
        hold_valid <= 1'b1;
        hold_addr  <= dl_addr;
        hold_data  <= dl_data;
      end else if (consume) hold_valid <= 1'b0;
      if (dl_wr && hold_valid && !consume) dl_overrun <= 1'b1;
      if (state == IDLE) begin
        if (hold_valid) begin
          gnt_dl   <= 1'b1;
          lat_addr <= hold_addr;
          lat_data <= hold_data;
          lat_we   <= 1'b1;
        end else if (!dl_active && found) begin
          gnt_dl   <= 1'b0;
          idx      <= sel;
          ptr      <= sel;
          lat_addr <= cl_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
          lat_data <= cl_wdata[sel*DATA_WIDTH +: DATA_WIDTH];
          lat_we   <= cl_we[sel];
        end
      end
      if (state == BUSY) begin
        cnt <= cnt + 16'd1;
        if (mem_ready) cl_rdata <= mem_dout;
        else if (timeout_hit) begin
          cl_rdata <= '1;
          err      <= 1'b1;
        end
      end
      if (state == DONE) begin
        cnt <= '0;
        err <= 1'b0;
      end
    end
  end
  assign mem_we   = state == BUSY && lat_we;
  assign mem_rd   = state == BUSY && !lat_we;
  assign mem_addr = lat_addr;
  assign mem_din  = lat_data;
  assign busy     = state != IDLE;
  assign cl_ack   = (state == DONE && !gnt_dl) ? NUM_CLIENTS'(1) << idx : '0;
  assign cl_err   = state == DONE && !gnt_dl && err;
endmodule
